// File: rtl/panel_row_shifter_if.sv
// Bundle between the row-period counter / frame store and the panel column/row drivers.
// Carries the refresh strobe, the fetched column word, the serial outputs and status.
interface panel_row_shifter_if #(
  parameter int COLS = 16,
  parameter int ROWS = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Handshake: row_tick is a one-cycle strobe with no back-pressure. It is
  // accepted only on an edge where busy==0. A strobe on any edge with busy==1
  // (including the edge on which busy falls) is dropped and sets the sticky
  // overrun flag. row_data must be valid for row_addr in the cycle row_tick is
  // high and is sampled only on the accepting edge.
  logic            row_tick;
  logic [COLS-1:0] row_data;
  logic            clr_overrun;
  logic [AW-1:0]   row_addr;
  logic            ser_clk;
  logic            ser_data;
  logic            ser_latch;
  logic [ROWS-1:0] row_sel;
  logic            busy;
  logic            overrun;
  logic [1:0]      state_dbg;

  modport master (
    output row_tick, row_data, clr_overrun,
    input  row_addr, ser_clk, ser_data, ser_latch, row_sel, busy, overrun, state_dbg
  );

  modport slave (
    input  row_tick, row_data, clr_overrun,
    output row_addr, ser_clk, ser_data, ser_latch, row_sel, busy, overrun, state_dbg
  );
endinterface

// File: rtl/panel_row_shifter.sv
// One row refresh per row_tick: shift the row's column word out MSB first,
// pulse the latch with rows blanked, then enable the refreshed row.
module panel_row_shifter #(
  parameter int COLS    = 16,
  parameter int ROWS    = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  panel_row_shifter_if.slave  bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = $clog2(COLS + 1);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(COLS - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t          state;
  logic [COLS-1:0] shreg;
  logic [BW-1:0]   bit_cnt;
  logic [PW-1:0]   phase;
  logic [AW-1:0]   row_addr_q;
  logic            ser_clk_q;
  logic            ser_data_q;
  logic            ser_latch_q;
  logic [ROWS-1:0] row_sel_q;
  logic            busy_q;
  logic            overrun_q;

  logic [COLS-1:0] shifted;
  logic [ROWS-1:0] row_onehot;

  assign shifted    = shreg << 1;
  assign row_onehot = ROWS'(1) << row_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      phase       <= '0;
      row_addr_q  <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
      row_sel_q   <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // A dropped strobe outranks a simultaneous clear so no overrun is lost.
      if (bus.row_tick && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.row_tick) begin
            shreg      <= bus.row_data;
            ser_data_q <= bus.row_data[COLS-1];
            ser_clk_q  <= 1'b0;
            bit_cnt    <= '0;
            phase      <= '0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (phase != LAST_PH) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (!ser_clk_q) begin
              ser_clk_q <= 1'b1;
            end else if (bit_cnt != LAST_BIT) begin
              // End of a high half: drop the clock and present the next bit together.
              ser_clk_q  <= 1'b0;
              shreg      <= shifted;
              ser_data_q <= shifted[COLS-1];
              bit_cnt    <= bit_cnt + 1'b1;
            end else begin
              ser_clk_q   <= 1'b0;
              ser_data_q  <= 1'b0;
              row_sel_q   <= '0;
              ser_latch_q <= 1'b1;
              state       <= LATCH;
            end
          end
        end

        LATCH: begin
          if (phase != LAST_PH) begin
            phase <= phase + 1'b1;
          end else begin
            phase       <= '0;
            ser_latch_q <= 1'b0;
            row_sel_q   <= row_onehot;
            row_addr_q  <= (row_addr_q == LAST_ROW) ? '0 : row_addr_q + 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.row_addr  = row_addr_q;
  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_latch = ser_latch_q;
  assign bus.row_sel   = row_sel_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_panel_row_shifter.sv
// Directed bench for panel_row_shifter: a default-size instance (16x8, CLK_DIV=2)
// and a small instance (4x2, CLK_DIV=1) share one clock and reset.
module tb_panel_row_shifter;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  panel_row_shifter_if #(.COLS(16), .ROWS(8)) bus_a();
  panel_row_shifter_if #(.COLS(4),  .ROWS(2)) bus_b();

  panel_row_shifter #(.COLS(16), .ROWS(8), .CLK_DIV(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  panel_row_shifter #(.COLS(4), .ROWS(2), .CLK_DIV(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic tick, input logic [31:0] data, input logic clr);
    if (which == 0) begin
      bus_a.row_tick    = tick;
      bus_a.row_data    = data[15:0];
      bus_a.clr_overrun = clr;
    end else begin
      bus_b.row_tick    = tick;
      bus_b.row_data    = data[3:0];
      bus_b.clr_overrun = clr;
    end
  endtask

  task automatic sample(input int which, output logic b, output logic sc, output logic sd,
                        output logic sl, output logic ov, output logic [31:0] rs,
                        output logic [31:0] ra, output logic [31:0] st);
    rs = '0;
    ra = '0;
    st = '0;
    if (which == 0) begin
      b = bus_a.busy; sc = bus_a.ser_clk; sd = bus_a.ser_data; sl = bus_a.ser_latch;
      ov = bus_a.overrun; rs[7:0] = bus_a.row_sel; ra[2:0] = bus_a.row_addr;
      st[1:0] = bus_a.state_dbg;
    end else begin
      b = bus_b.busy; sc = bus_b.ser_clk; sd = bus_b.ser_data; sl = bus_b.ser_latch;
      ov = bus_b.overrun; rs[1:0] = bus_b.row_sel; ra[0] = bus_b.row_addr;
      st[1:0] = bus_b.state_dbg;
    end
  endtask

  task automatic check_rst(input string tag, input int which);
    logic b, sc, sd, sl, ov;
    logic [31:0] rs, ra, st;
    sample(which, b, sc, sd, sl, ov, rs, ra, st);
    check(tag, {ra[7:0], rs[7:0], st[1:0], b, sc, sd, sl, ov}, 32'h0);
  endtask

  task automatic clr_pulse(input string tag);
    drive(0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    check(tag, {31'h0, bus_a.overrun}, 32'h0);
  endtask

  // One refresh from a tick issued now (caller sits just after a falling edge).
  // tick_at/data_at/clr_at are busy-cycle numbers at which a second tick, a
  // row_data change or a clr_overrun is driven (-1 = never).
  task automatic refresh(input string tag, input int which, input logic [31:0] d,
                         input int tick_at, input int data_at, input int clr_at,
                         input int exp_busy, input int exp_latch, input int exp_rises,
                         input int exp_tog, input logic [31:0] exp_sel,
                         input logic [31:0] exp_addr, input logic exp_ov);
    logic [31:0] word = '0;
    logic [31:0] cur  = d;
    int cyc = 0, lat = 0, rises = 0, bad = 0, tog = 0;
    logic prev = 1'b0;
    logic b, sc, sd, sl, ov;
    logic [31:0] rs, ra, st;
    exp_q.push_back(d);
    drive(which, 1'b1, cur, 1'b0);
    @(negedge clk);
    sample(which, b, sc, sd, sl, ov, rs, ra, st);
    while (b && cyc < 200) begin
      cyc++;
      if (sl) begin
        lat++;
        if (rs != 0) bad++;
      end
      if (sc && !prev) begin
        word = (word << 1) | {31'h0, sd};
        rises++;
      end
      if (cyc > 1 && sc != prev && !sl) tog++;
      prev = sc;
      if (cyc == data_at) cur = ~cur;
      drive(which, (cyc == tick_at), cur, (cyc == clr_at));
      @(negedge clk);
      sample(which, b, sc, sd, sl, ov, rs, ra, st);
    end
    drive(which, 1'b0, cur, 1'b0);
    check({tag, "_word"},    word, exp_q.pop_front());
    check({tag, "_busy"},    cyc, exp_busy);
    check({tag, "_latch"},   lat, exp_latch);
    check({tag, "_rises"},   rises, exp_rises);
    check({tag, "_toggles"}, tog, exp_tog);
    check({tag, "_blank"},   bad, 0);
    check({tag, "_rowsel"},  rs, exp_sel);
    check({tag, "_rowaddr"}, ra, exp_addr);
    check({tag, "_overrun"}, {31'h0, ov}, {31'h0, exp_ov});
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] walk_tbl [8] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8001,
                                16'h5555, 16'hAAAA, 16'h0F0F, 16'hF00D};

  initial begin
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);

    // Reset held with random inputs, then released.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_rst("rst_hold_a", 0);
      check_rst("rst_hold_b", 1);
      drive(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      drive(1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_rst("rst_rel_a", 0);
    check_rst("rst_rel_b", 1);

    // Basic refresh of 16'hA5C3.
    refresh("a5c3", 0, 32'hA5C3, -1, -1, -1, 66, 2, 16, 31, 32'h01, 32'd1, 1'b0);

    // Eight ticks spaced 70 cycles: row_sel walks, row_addr wraps.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      refresh($sformatf("walk%0d", i), 0, {16'h0, walk_tbl[i]}, -1, -1, -1,
              66, 2, 16, 31, 32'h1 << i, (i + 1) % 8, 1'b0);
    end

    // Tick 10 cycles into a refresh: flagged, refresh undisturbed.
    refresh("ovr", 0, 32'h3C5A, 10, -1, -1, 66, 2, 16, 31, 32'h01, 32'd1, 1'b1);
    clr_pulse("ovr_clr");

    // Clear and overrun tick on the same edge: set wins.
    refresh("ovr_clr_same", 0, 32'hFFFF, 20, -1, 20, 66, 2, 16, 31, 32'h02, 32'd2, 1'b1);
    clr_pulse("ovr_clr2");

    // Tick on the edge busy falls is rejected; the next edge is accepted, and
    // row_data changing after the tick does not alter the shifted word.
    refresh("fall_tick", 0, 32'h0001, 66, -1, -1, 66, 2, 16, 31, 32'h04, 32'd3, 1'b1);
    refresh("after_fall", 0, 32'h8000, -1, 1, -1, 66, 2, 16, 31, 32'h08, 32'd4, 1'b1);
    clr_pulse("ovr_clr3");

    // Asynchronous reset in the middle of a shift.
    drive(0, 1'b1, 32'hBEEF, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'hBEEF, 1'b0);
    repeat (20) @(negedge clk);
    check("pre_rst_busy", {31'h0, bus_a.busy}, 32'h1);
    #2 reset = 1'b0;
    #1 check_rst("async_rst_a", 0);
    @(negedge clk);
    reset = 1'b1;

    // Small instance: 4 columns, 2 rows, serial clock toggling every cycle.
    refresh("b_1001", 1, 32'h9, -1, -1, -1, 9, 1, 4, 7, 32'h1, 32'd1, 1'b0);
    refresh("b_0110", 1, 32'h6, -1, -1, -1, 9, 1, 4, 7, 32'h2, 32'd0, 1'b0);
    refresh("b_1111", 1, 32'hF, -1, -1, -1, 9, 1, 4, 7, 32'h1, 32'd1, 1'b0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
